// File: rtl/addsub_issuer.sv
// rtl/addsub_issuer.sv - initiator for the FDTD ALU add/sub unit with in-order, credit-protected result FIFO
//
// Purpose: accepts tagged add/subtract requests, drives the registered add/sub
// unit for one cycle, captures its result one cycle later and queues it in a
// small FIFO. Requests are only accepted when a FIFO slot is guaranteed for the
// result, so downstream backpressure can never drop a result.
//
// Build option: ADDSUB_ISSUER_SAT_EN
//   defined   - signed overflow is detected, results are saturated, RSP_OVF reports it
//   undefined - results wrap (raw AS_S), RSP_OVF is tied to 0
//
// Ports:
//   CLK, RST_N                   clock, synchronous active-low reset
//   REQ_VALID/REQ_READY          request handshake
//   REQ_ADD, REQ_A, REQ_B        op select (1 = A+B, 0 = A-B) and signed operands
//   REQ_TAG                      opaque tag returned with the result
//   AS_CE, AS_ADD, AS_A, AS_B    to the add/sub unit (zero when not issuing)
//   AS_S                         from the add/sub unit, valid one cycle after AS_CE
//   RSP_VALID/RSP_READY          result handshake
//   RSP_S, RSP_TAG, RSP_OVF      head-of-FIFO result (zero when empty)
//   CNT                          FIFO occupancy

module addsub_issuer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_ADD,
  input  logic [WIDTH-1:0]         REQ_A,
  input  logic [WIDTH-1:0]         REQ_B,
  input  logic [TAG_W-1:0]         REQ_TAG,
  output logic                     AS_CE,
  output logic                     AS_ADD,
  output logic [WIDTH-1:0]         AS_A,
  output logic [WIDTH-1:0]         AS_B,
  input  logic [WIDTH-1:0]         AS_S,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [WIDTH-1:0]         RSP_S,
  output logic [TAG_W-1:0]         RSP_TAG,
  output logic                     RSP_OVF,
  output logic [$clog2(DEPTH):0]   CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             issue;
  logic             push;
  logic             pop;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             infl_v;
  logic [TAG_W-1:0] infl_tag;
  logic [WIDTH-1:0] wr_s;

  logic [WIDTH-1:0] mem_s   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  // Credit check counts the in-flight result as already occupying a slot.
  // Same-cycle pops are deliberately not credited to keep this path short.
  assign REQ_READY = RST_N & (({1'b0, cnt} + {{CW{1'b0}}, infl_v}) < (CW+1)'(DEPTH));
  assign issue     = REQ_VALID & REQ_READY;

  assign AS_CE  = issue;
  assign AS_ADD = issue ? REQ_ADD : 1'b0;
  assign AS_A   = issue ? REQ_A   : '0;
  assign AS_B   = issue ? REQ_B   : '0;

  // The unit's output is only meaningful the cycle after an issue.
  assign push = infl_v;
  assign pop  = RSP_VALID & RSP_READY;

  assign RSP_VALID = RST_N & (cnt != '0);
  assign RSP_S     = RSP_VALID ? mem_s[rd_ptr]   : '0;
  assign RSP_TAG   = RSP_VALID ? mem_tag[rd_ptr] : '0;
  assign CNT       = RST_N ? cnt : '0;

`ifdef ADDSUB_ISSUER_SAT_EN
  logic             infl_add;
  logic             infl_a_sgn;
  logic             infl_b_sgn;
  logic             ovf;
  logic             mem_ovf [DEPTH];

  // In both overflow cases the true result has the sign of A, so the
  // saturation direction follows A's sign.
  assign ovf = (infl_add ? (infl_a_sgn == infl_b_sgn) : (infl_a_sgn != infl_b_sgn))
               & (AS_S[WIDTH-1] != infl_a_sgn);

  always_comb begin
    wr_s = AS_S;
    if (ovf) begin
      wr_s = infl_a_sgn ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) begin
      infl_add   <= REQ_ADD;
      infl_a_sgn <= REQ_A[WIDTH-1];
      infl_b_sgn <= REQ_B[WIDTH-1];
    end
    if (push) begin
      mem_ovf[wr_ptr] <= ovf;
    end
  end

  assign RSP_OVF = RSP_VALID ? mem_ovf[rd_ptr] : 1'b0;
`else
  assign wr_s    = AS_S;
  assign RSP_OVF = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      infl_v <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        infl_tag <= REQ_TAG;
      end
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through cnt.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_s[wr_ptr]   <= wr_s;
      mem_tag[wr_ptr] <= infl_tag;
    end
  end

endmodule

// File: tb/tb_addsub_issuer.sv
// tb/tb_addsub_issuer.sv - directed self-checking bench for addsub_issuer

module tb_addsub_issuer;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_add;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [TW-1:0] req_tag;
  logic          as_ce;
  logic          as_add;
  logic [W-1:0]  as_a;
  logic [W-1:0]  as_b;
  logic [W-1:0]  as_s = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_s;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ovf;
  logic [$clog2(D):0] cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ovf_add_s;
  logic [W-1:0] ovf_sub_s;
  logic         ovf_flag;

  always #5 clk = ~clk;

  addsub_issuer #(.WIDTH(W), .TAG_W(TW), .DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADD(req_add),
    .REQ_A(req_a), .REQ_B(req_b), .REQ_TAG(req_tag),
    .AS_CE(as_ce), .AS_ADD(as_add), .AS_A(as_a), .AS_B(as_b), .AS_S(as_s),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_S(rsp_s),
    .RSP_TAG(rsp_tag), .RSP_OVF(rsp_ovf), .CNT(cnt)
  );

  // Registered add/sub unit: one-cycle latency, output 0 when not enabled.
  always @(posedge clk) begin
    as_s <= as_ce ? (as_add ? as_a + as_b : as_a - as_b) : '0;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic add, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag);
    req_valid = v;
    req_add   = add;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  task automatic head(input string name, input logic [W-1:0] s, input logic [TW-1:0] tag);
    chk({name, "_valid"}, rsp_valid, 1);
    chk({name, "_s"}, rsp_s, s);
    chk({name, "_tag"}, rsp_tag, tag);
  endtask

  initial begin
`ifdef ADDSUB_ISSUER_SAT_EN
    ovf_add_s = 32'h7FFF_FFFF;
    ovf_sub_s = 32'h8000_0000;
    ovf_flag  = 1'b1;
`else
    ovf_add_s = 32'h8000_0000;
    ovf_sub_s = 32'h7FFF_FFFF;
    ovf_flag  = 1'b0;
`endif

    // Reset with a request offered: nothing may be accepted or shown.
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive(1, 1, 1, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_as_ce", as_ce, 0);
    chk("reset_as_a", as_a, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_s", rsp_s, 0);
    chk("reset_cnt", cnt, 0);

    rst_n = 1'b1;
    rsp_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);

    // 5 + 7, tag 3: result visible exactly two cycles after the handshake.
    drive(1, 1, 5, 7, 3);
    #1;
    chk("add_as_ce", as_ce, 1);
    chk("add_as_add", as_add, 1);
    chk("add_as_a", as_a, 5);
    chk("add_as_b", as_b, 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("add_as_ce_off", as_ce, 0);
    chk("add_lat1_valid", rsp_valid, 0);
    @(negedge clk);
    head("add", 12, 3);
    chk("add_ovf", rsp_ovf, 0);
    chk("add_cnt", cnt, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("add_pop_valid", rsp_valid, 0);
    chk("add_pop_s", rsp_s, 0);
    rsp_ready = 1'b0;

    // 5 - 7, tag 9.
    drive(1, 0, 5, 7, 9);
    #1;
    chk("sub_as_add", as_add, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    head("sub", 32'hFFFF_FFFE, 9);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("sub_pop_cnt", cnt, 0);

    // Back-to-back i+i, i = 0..15, consumer always ready.
    for (int j = 0; j < 18; j++) begin
      if (j < 16) drive(1, 1, W'(j), W'(j), TW'(j));
      else drive(0, 0, 0, 0, 0);
      #1;
      if (j < 16) chk("b2b_req_ready", req_ready, 1);
      if (j >= 2) head("b2b", W'(2 * (j - 2)), TW'(j - 2));
      @(negedge clk);
    end
    chk("b2b_end_cnt", cnt, 0);

    // Backpressure: exactly DEPTH accepted, then drain in order.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, W'(10 + k), W'(k), TW'(k));
      #1;
      chk("bp_accept_ready", req_ready, 1);
      @(negedge clk);
    end
    drive(1, 1, 14, 4, 4);
    #1;
    chk("bp_stall_ready", req_ready, 0);
    @(negedge clk);
    chk("bp_full_ready", req_ready, 0);
    chk("bp_full_cnt", cnt, 4);
    head("bp_r0", 10, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_pop_not_credited", req_ready, 0);
    @(negedge clk);
    head("bp_r1", 12, 1);
    chk("bp_r1_cnt", cnt, 3);
    chk("bp_req4_ready", req_ready, 1);
    @(negedge clk);
    head("bp_r2", 14, 2);
    chk("bp_r2_cnt", cnt, 2);
    drive(1, 1, 15, 5, 5);
    #1;
    chk("bp_req5_ready", req_ready, 1);
    @(negedge clk);
    head("bp_r3", 16, 3);
    chk("bp_r3_cnt", cnt, 2);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    head("bp_r4", 18, 4);
    @(negedge clk);
    head("bp_r5", 20, 5);
    @(negedge clk);
    chk("bp_empty", rsp_valid, 0);

    // Signed overflow at both ends of the range.
    drive(1, 1, 32'h7FFF_FFFF, 1, 1);
    @(negedge clk);
    drive(1, 0, 32'h8000_0000, 1, 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    head("ovf_add", ovf_add_s, 1);
    chk("ovf_add_flag", rsp_ovf, ovf_flag);
    @(negedge clk);
    head("ovf_sub", ovf_sub_s, 2);
    chk("ovf_sub_flag", rsp_ovf, ovf_flag);
    @(negedge clk);
    chk("ovf_empty", rsp_valid, 0);

    // Push and pop together at CNT = DEPTH-1 while the write pointer wraps.
    rsp_ready = 1'b0;
    drive(1, 1, 100, 1, 8);
    @(negedge clk);
    drive(1, 1, 100, 2, 9);
    @(negedge clk);
    drive(1, 1, 100, 3, 10);
    @(negedge clk);
    drive(1, 1, 100, 4, 11);
    #1;
    chk("wrap_req_ready", req_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("wrap_pre_cnt", cnt, 3);
    head("wrap_a", 101, 8);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("wrap_pushpop_cnt", cnt, 3);
    head("wrap_b", 102, 9);
    @(negedge clk);
    head("wrap_c", 103, 10);
    @(negedge clk);
    head("wrap_d", 104, 11);
    @(negedge clk);
    chk("wrap_empty", rsp_valid, 0);

    // Reset with one in flight and three stored results.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 1, TW'(k));
      @(negedge clk);
    end
    chk("rst_pre_cnt", cnt, 3);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst_low_req_ready", req_ready, 0);
    chk("rst_low_rsp_valid", rsp_valid, 0);
    chk("rst_low_cnt", cnt, 0);
    @(negedge clk);
    chk("rst_after_cnt", cnt, 0);
    chk("rst_after_rsp_valid", rsp_valid, 0);
    chk("rst_after_req_ready", req_ready, 0);
    chk("rst_after_rsp_s", rsp_s, 0);
    rst_n = 1'b1;
    drive(1, 1, 2, 2, 6);
    #1;
    chk("rst_rel_req_ready", req_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("rst_no_stale_valid", rsp_valid, 0);
    chk("rst_no_stale_cnt", cnt, 0);
    @(negedge clk);
    head("rst_fresh", 4, 6);
    chk("rst_fresh_cnt", cnt, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_fresh_drained", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
